// File: rtl/accel_pkg.sv
// Shared encodings and loop bounds for the dot-product / 2x2 matmul sequencer.
package accel_pkg;

    localparam logic OP_DOT4      = 1'b0;
    localparam logic OP_MATMUL2x2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int DOT_MACS        = 4;
    localparam int MM_MACS_PER_OUT = 2;
    localparam int MM_OUTS         = 4;

endpackage

// File: rtl/accel_mac.sv
// Registered signed multiply-accumulate; one product per enabled cycle, clear wins over enable.
// sum_o is the accumulator plus the current product, so a caller can capture a final result on the last MAC edge.
module accel_mac #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [ELEM_W-1:0] a_i,
    input  logic [ELEM_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o
);

    logic signed [2*ELEM_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           acc_q;
    logic [ACC_W-1:0]           acc_d;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = {{(ACC_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
    assign sum_o    = acc_q + prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/accel_seq.sv
// Sequences DOT4 (5 cycles start->done) and MATMUL2x2 (12 cycles) over one shared MAC, writing results back.
// No backpressure: busy holds the pipeline; start while busy is dropped, flush aborts with no write.
module accel_seq
    import accel_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                op,
    input  logic                relu,
    input  logic [REG_AW-1:0]   rd,
    input  logic [4*ELEM_W-1:0] a_vec,
    input  logic [4*ELEM_W-1:0] b_vec,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic [REG_AW-1:0]   wr_addr,
    output logic [ACC_W-1:0]    wr_data
);

    state_t                state_q;
    logic                  op_q;
    logic                  relu_q;
    logic [REG_AW-1:0]     rd_q;
    logic [4*ELEM_W-1:0]   a_q;
    logic [4*ELEM_W-1:0]   b_q;
    logic [1:0]            k_q;
    logic [1:0]            m_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_en_q;
    logic [REG_AW-1:0]     wr_addr_q;
    logic [ACC_W-1:0]      wr_data_q;

    logic [1:0]            a_idx;
    logic [1:0]            b_idx;
    logic [ELEM_W-1:0]     a_sel;
    logic [ELEM_W-1:0]     b_sel;
    logic                  mac_clr;
    logic                  mac_en;
    logic [ACC_W-1:0]      mac_sum;
    logic                  last_mac;
    logic                  last_out;
    logic [REG_AW-1:0]     wb_addr_d;
    logic [ACC_W-1:0]      wb_data_d;

    // Matmul output k=(i,j): step m pairs a[i][m] with b[m][j].
    always_comb begin
        a_idx = m_q;
        b_idx = m_q;
        if (op_q == OP_MATMUL2x2) begin
            a_idx = {k_q[1], m_q[0]};
            b_idx = {m_q[0], k_q[0]};
        end
    end

    assign a_sel = a_q[int'(a_idx)*ELEM_W +: ELEM_W];
    assign b_sel = b_q[int'(b_idx)*ELEM_W +: ELEM_W];

    assign mac_clr = flush || (state_q == WB) || (state_q == IDLE && start);
    assign mac_en  = (state_q == MAC);

    accel_mac #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .a_i     (a_sel),
        .b_i     (b_sel),
        .sum_o   (mac_sum)
    );

    assign last_mac  = (op_q == OP_DOT4) ? (m_q == 2'(DOT_MACS-1))
                                         : (m_q == 2'(MM_MACS_PER_OUT-1));
    assign last_out  = (op_q == OP_DOT4) || (k_q == 2'(MM_OUTS-1));
    assign wb_addr_d = rd_q + REG_AW'(k_q);
    assign wb_data_d = (relu_q && mac_sum[ACC_W-1]) ? '0 : mac_sum;

    // Writeback outputs are loaded on the last MAC edge so they are visible during the WB cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= OP_DOT4;
            relu_q    <= 1'b0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                k_q     <= '0;
                m_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            op_q    <= op;
                            relu_q  <= relu;
                            rd_q    <= rd;
                            a_q     <= a_vec;
                            b_q     <= b_vec;
                            k_q     <= '0;
                            m_q     <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MAC;
                        end
                    end
                    MAC: begin
                        if (last_mac) begin
                            m_q     <= '0;
                            state_q <= WB;
                            done_q  <= last_out;
                            if (wb_addr_d != '0) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= wb_addr_d;
                                wr_data_q <= wb_data_d;
                            end
                        end else begin
                            m_q <= m_q + 2'd1;
                        end
                    end
                    WB: begin
                        if (last_out) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            k_q     <= k_q + 2'd1;
                            state_q <= MAC;
                        end
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_accel_seq.sv
// Directed bench for accel_seq: cycle-exact busy/done/write checks for DOT4, MATMUL2x2, ReLU, x0 suppression,
// ignored restarts, asynchronous reset and flush aborts.
module tb_accel_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic        relu;
    logic [4:0]  rd;
    logic [31:0] a_vec;
    logic [31:0] b_vec;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr0;
    int dn0;

    accel_seq #(
        .ELEM_W (8),
        .ACC_W  (32),
        .REG_AW (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .relu    (relu),
        .rd      (rd),
        .a_vec   (a_vec),
        .b_vec   (b_vec),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    // Issues one instruction and checks every cycle up to and including the cycle after done.
    // ea/ed give the expected wr_addr/wr_data in each WB slot (held values where the write is suppressed).
    task automatic run_inst(input string tag, input logic op_v, input logic relu_v, input logic [4:0] rd_v,
                            input logic [31:0] a_v, input logic [31:0] b_v, input logic [3:0] we,
                            input logic [3:0][4:0] ea, input logic [3:0][31:0] ed, input int restart_c);
        int len;
        int nwe;
        int s;
        int w0;
        bit is_wb;
        len = op_v ? 12 : 5;
        nwe = op_v ? $countones(we) : int'(we[0]);
        w0  = wr_cnt;
        op = op_v; relu = relu_v; rd = rd_v; a_vec = a_v; b_vec = b_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= len; c++) begin
            is_wb = op_v ? (c % 3 == 0) : (c == 5);
            s = 0;
            if (op_v && is_wb) s = c / 3 - 1;
            chk({tag, ".busy"}, busy, 1'b1);
            chk({tag, ".done"}, done, (c == len));
            chk({tag, ".wr_en"}, wr_en, is_wb ? we[s] : 1'b0);
            if (is_wb) begin
                chk({tag, ".wr_addr"}, wr_addr, ea[s]);
                chk({tag, ".wr_data"}, wr_data, ed[s]);
            end
            start = (c == restart_c);
            if (c == restart_c) begin
                op = ~op_v; rd = 5'd0;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, ".busy_after"}, busy, 1'b0);
        chk({tag, ".done_after"}, done, 1'b0);
        chk({tag, ".wr_en_after"}, wr_en, 1'b0);
        chk({tag, ".num_writes"}, wr_cnt - w0, nwe);
    endtask

    initial begin
        reset_n = 1'b1;
        start = 1'b0; op = 1'b0; relu = 1'b0; rd = '0;
        a_vec = '0; b_vec = '0; flush = 1'b0;
        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.wr_en", wr_en, 1'b0);
        chk("rst.wr_addr", wr_addr, 5'd0);
        chk("rst.wr_data", wr_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // DOT4 then MATMUL back-to-back: second start lands in the cycle after done.
        run_inst("dot4", 1'b0, 1'b0, 5'd7, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0001,
                 {5'd0, 5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'd0, 32'd70}, 0);
        run_inst("mm", 1'b1, 1'b0, 5'd12, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111,
                 {5'd15, 5'd14, 5'd13, 5'd12}, {32'd50, 32'd43, 32'd22, 32'd19}, 0);

        run_inst("relu_neg", 1'b0, 1'b1, 5'd2, pack4(-1, 0, 0, 0), pack4(5, 0, 0, 0), 4'b0001,
                 {5'd0, 5'd0, 5'd0, 5'd2}, {32'd0, 32'd0, 32'd0, 32'd0}, 0);
        run_inst("norelu_neg", 1'b0, 1'b0, 5'd2, pack4(-1, 0, 0, 0), pack4(5, 0, 0, 0), 4'b0001,
                 {5'd0, 5'd0, 5'd0, 5'd2}, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB}, 0);
        run_inst("min_sq", 1'b0, 1'b1, 5'd3, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128),
                 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'd0, 32'd65536}, 0);

        // rd=30 wraps through x0: that slot is silent and the outputs hold r31/22.
        run_inst("mm_wrap", 1'b1, 1'b0, 5'd30, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1011,
                 {5'd1, 5'd31, 5'd31, 5'd30}, {32'd50, 32'd22, 32'd22, 32'd19}, 0);

        run_inst("restart", 1'b0, 1'b0, 5'd9, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0001,
                 {5'd0, 5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'd0, 32'd70}, 3);

        // Asynchronous reset in MATMUL cycle 5.
        op = 1'b1; relu = 1'b0; rd = 5'd12; a_vec = pack4(1, 2, 3, 4); b_vec = pack4(5, 6, 7, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("arst.pre_addr", wr_addr, 5'd12);
        chk("arst.pre_busy", busy, 1'b1);
        wr0 = wr_cnt; dn0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("arst.busy", busy, 1'b0);
        chk("arst.done", done, 1'b0);
        chk("arst.wr_en", wr_en, 1'b0);
        chk("arst.wr_addr", wr_addr, 5'd0);
        chk("arst.wr_data", wr_data, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("arst.no_writes", wr_cnt - wr0, 0);
        chk("arst.no_done", done_cnt - dn0, 0);
        chk("arst.busy_after", busy, 1'b0);

        // Flush in DOT4 cycle 3.
        op = 1'b0; rd = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        wr0 = wr_cnt; dn0 = done_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", busy, 1'b0);
        chk("flush.done", done, 1'b0);
        chk("flush.wr_en", wr_en, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("flush.no_writes", wr_cnt - wr0, 0);
        chk("flush.no_done", done_cnt - dn0, 0);

        // flush and start together in IDLE: start is dropped.
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start.busy", busy, 1'b0);
        tick();
        tick();
        chk("flush_start.busy_later", busy, 1'b0);
        chk("flush_start.no_writes", wr_cnt - wr0, 0);

        run_inst("post_abort", 1'b0, 1'b0, 5'd1, pack4(1, 1, 1, 1), pack4(2, 3, 4, 5), 4'b0001,
                 {5'd0, 5'd0, 5'd0, 5'd1}, {32'd0, 32'd0, 32'd0, 32'd14}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
